// File: rtl/tetris_row_fetcher.sv
// rtl/tetris_row_fetcher.sv - board row prefetch during hblank and per-pixel cell coordinate/colour sequencer
module tetris_row_fetcher #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int CELL_W  = 26,
  parameter int CELL_H  = 32,
  parameter int X0      = 192,
  parameter int Y0      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [9:0]  fetch_y,
  input  logic        px_valid,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  output logic        ram_req,
  output logic [7:0]  ram_addr,
  input  logic        ram_gnt,
  input  logic [2:0]  ram_rdata,
  output logic        sh_valid,
  output logic        in_board,
  output logic [5:0]  block_x,
  output logic [5:0]  block_y,
  output logic [11:0] in_color,
  output logic        busy,
  output logic        underrun
);

  localparam int CY_W  = $clog2(CELL_H);
  localparam int ROW_W = $clog2(BOARD_H + 1);
  localparam int COL_W = $clog2(BOARD_W + 1);
  localparam int BX_W  = $clog2(CELL_W);
  localparam logic [10:0] BOARD_PIX = 11'(BOARD_H * CELL_H);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t state, state_n;

  logic [ROW_W-1:0] last_row;
  logic [ROW_W-1:0] fetch_row;
  logic             row_valid;
  logic [COL_W-1:0] col_req;
  logic             acc_d;
  logic [COL_W-1:0] acc_col;
  logic [2:0]       back  [BOARD_W];
  logic [2:0]       front [BOARD_W];

  logic [BX_W-1:0]  walk_bx;
  logic [COL_W-1:0] walk_col;
  logic             walk_on;

  // Row decode for the line about to be displayed
  logic [10:0]      dy;
  logic             line_in_board;
  logic [ROW_W-1:0] row_calc;
  logic             go_fetch;

  assign dy            = {1'b0, fetch_y} - 11'(Y0);
  assign line_in_board = !dy[10] && (dy < BOARD_PIX);
  assign row_calc      = ROW_W'(dy >> CY_W);
  assign go_fetch      = line_in_board && (row_calc != last_row);

  logic start_fetch, invalidate, accept, commit;

  // A line_start in any state re-runs the idle decision; mid-fetch this is an abort.
  always_comb begin
    state_n     = state;
    start_fetch = 1'b0;
    invalidate  = 1'b0;
    accept      = 1'b0;
    commit      = 1'b0;
    if (line_start) begin
      state_n     = go_fetch ? REQ : IDLE;
      start_fetch = go_fetch;
      invalidate  = !line_in_board;
    end else begin
      case (state)
        REQ: begin
          if (ram_gnt) begin
            accept = 1'b1;
            if (col_req == COL_W'(BOARD_W - 1)) state_n = DRAIN;
          end
        end
        DRAIN: begin
          commit  = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic [7:0] addr_calc;
  assign addr_calc = 8'(fetch_row) * 8'(BOARD_W) + 8'(col_req);
  assign ram_req   = (state == REQ);
  assign ram_addr  = ram_req ? addr_calc : 8'd0;
  assign busy      = (state != IDLE);

  // Horizontal walk: derive this pixel's cell position from the previous strobe
  logic [BX_W-1:0]  cur_bx;
  logic [COL_W-1:0] cur_col;
  logic             cur_in;

  always_comb begin
    cur_bx  = '0;
    cur_col = '0;
    cur_in  = 1'b0;
    if (px_x == 10'(X0)) begin
      cur_in = 1'b1;
    end else if ((px_x > 10'(X0)) && walk_on) begin
      if (walk_bx == BX_W'(CELL_W - 1)) begin
        cur_col = walk_col + COL_W'(1);
        cur_in  = (cur_col < COL_W'(BOARD_W));
      end else begin
        cur_bx  = walk_bx + BX_W'(1);
        cur_col = walk_col;
        cur_in  = 1'b1;
      end
    end
  end

  function automatic logic [11:0] palette(input logic [2:0] code);
    case (code)
      3'd1:    palette = 12'h0FF;
      3'd2:    palette = 12'h00F;
      3'd3:    palette = 12'hF80;
      3'd4:    palette = 12'hFF0;
      3'd5:    palette = 12'h0F0;
      3'd6:    palette = 12'hF0F;
      3'd7:    palette = 12'hF00;
      default: palette = 12'h000;
    endcase
  endfunction

  logic            pix_in;
  logic [2:0]      code_sel;
  logic [CY_W-1:0] py_low;
  logic            unused_py;

  assign pix_in    = px_valid && row_valid && cur_in;
  assign code_sel  = cur_in ? front[cur_col] : 3'd0;
  assign py_low    = px_y[CY_W-1:0] - CY_W'(Y0);
  assign unused_py = ^px_y[9:CY_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_row  <= '1;
      fetch_row <= '0;
      row_valid <= 1'b0;
      col_req   <= '0;
      acc_d     <= 1'b0;
      acc_col   <= '0;
      for (int i = 0; i < BOARD_W; i++) begin
        back[i]  <= 3'd0;
        front[i] <= 3'd0;
      end
      walk_bx   <= '0;
      walk_col  <= '0;
      walk_on   <= 1'b0;
      underrun  <= 1'b0;
      sh_valid  <= 1'b0;
      in_board  <= 1'b0;
      block_x   <= 6'd0;
      block_y   <= 6'd0;
      in_color  <= 12'd0;
    end else begin
      state <= state_n;

      if (start_fetch) begin
        col_req   <= '0;
        fetch_row <= row_calc;
      end else if (accept) begin
        col_req <= col_req + COL_W'(1);
      end

      acc_d   <= accept;
      acc_col <= col_req;
      // Read data landing on an abort cycle belongs to the discarded fetch
      if (acc_d && !line_start) back[acc_col] <= ram_rdata;

      // The last column's data arrives in the commit cycle, so bypass it into front
      if (commit) begin
        for (int i = 0; i < BOARD_W; i++)
          front[i] <= (acc_d && (acc_col == COL_W'(i))) ? ram_rdata : back[i];
        row_valid <= 1'b1;
        last_row  <= fetch_row;
      end else if (invalidate) begin
        row_valid <= 1'b0;
        last_row  <= '1;
      end

      if (px_valid && (state != IDLE)) underrun <= 1'b1;

      if (px_valid) begin
        walk_bx  <= cur_bx;
        walk_col <= cur_col;
        walk_on  <= cur_in;
      end

      sh_valid <= px_valid;
      in_board <= pix_in;
      block_x  <= pix_in ? 6'(cur_bx) : 6'd0;
      block_y  <= pix_in ? 6'(py_low) : 6'd0;
      in_color <= pix_in ? palette(code_sel) : 12'd0;
    end
  end

endmodule
